imm_packer: RTL and testbench
=============================

Name: imm_packer

Overview:
- Inverse of the immediate extender: takes an instruction template, an immediate value and an immediate type, and inserts the immediate into that type's RISC-V bit fields.
- Checks that the immediate is representable (range and alignment) for the chosen type.
- 2-stage valid/ready pipeline. Sits between the test/boot instruction generator (or self-modifying patch logic) and instruction memory write port.

Parameters:
- CNT_W, 16, width of the saturating error counter.
- ERR_ZERO, 0, if 1 an erroneous word has all its immediate fields forced to 0; if 0 the fields carry the truncated immediate.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_instr  in  32  instruction template; bits in immediate positions are ignored.
- in_immsrc  in  2  immediate type: 00 I, 01 S, 10 B, 11 J.
- in_imm  in  32  immediate, two's complement.
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts the word.
- out_instr  out  32  packed instruction.
- out_err  out  1  immediate not representable for its type.
- err_count  out  CNT_W  errored words delivered (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: s1_valid=0, out_valid=0, out_instr=0, out_err=0, err_count=0. Asserting reset mid-operation drops every in-flight word.
- Handshake:
  - Input transfers on in_valid && in_ready.
  - Output transfers on out_valid && out_ready.
  - out_valid, out_instr and out_err hold stable while out_valid && !out_ready.
- Stage 1 (check) registers in_instr, in_immsrc, in_imm and err.
- Stage 2 (pack) registers out_instr and out_err.
- Flow control:
  - s2_free = !out_valid || out_ready.
  - Stage 1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational from out_ready, with no combinational path from in_valid.
- Latency: a word accepted at edge k appears with out_valid at edge k+1 (visible after k+1). Two register stages give 1 accept-to-output cycle; throughput is 1 word/cycle with out_ready held high.
- Range/alignment rules, err=1 if violated:
  - I: in_imm[31:11] all equal.
  - S: in_imm[31:11] all equal.
  - B: in_imm[31:12] all equal and in_imm[0]==0.
  - J: in_imm[31:20] all equal and in_imm[0]==0.
- Packing. Template bits outside the listed fields pass through unchanged (opcode, rd/rs, funct):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Error word: still emitted, never dropped. out_err=1; fields are truncated, or zero when ERR_ZERO=1.
- Simultaneous output transfer and stage-1 advance in the same cycle: the new word replaces the old with no bubble.

Optional Feature:
- IMM_PACK_ERRCNT_EN defined:
  - err_count increments by 1 on each output transfer with out_err=1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It is cleared only by reset.
- Undefined: err_count is tied to 0 and the counter logic is absent. The port list is unchanged.

Decomposition:
- Shared package, also used by the immediate extender and the decoder:
  - immsrc encodings IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11.
  - Field bit-position constants.
- One natural sub-module: imm_range_chk, combinational (imm, immsrc) -> err, instantiated in stage 1.

Test Plan:
- I pack: template 0x00000093, imm=5, immsrc=00 -> out_instr=0x00500093, out_err=0, one cycle after accept.
- S and B pack:
  - S: template 0x0020A023, imm=8 -> 0x0020A423.
  - B: template 0x00000063, imm=-4 (0xFFFFFFFC) -> 0xFE000EE3, err=0.
- J pack: template 0x0000006F, imm=0x800 -> 0x0010006F. Feeding the output to the immediate extender returns 0x00000800.
- Errors:
  - I imm=2048 -> out_err=1, out_instr=0x80000093 (ERR_ZERO=0) or 0x00000093 (ERR_ZERO=1).
  - B imm=3 -> out_err=1.
  - With IMM_PACK_ERRCNT_EN, err_count=2 after both are delivered.
- Backpressure/reset:
  - Stream 4 words with out_ready low for 3 cycles: in_ready drops after 2 words are held, outputs stay stable, all 4 arrive in order, none lost or duplicated.
  - rst_n pulsed low asynchronously mid-stream -> out_valid=0 immediately, err_count=0.

Source files
------------

// File: rtl/imm_packer_pkg.sv
// Shared immediate-format definitions: immsrc encodings, RISC-V immediate
// field positions and the scatter helper used to pack an immediate into a word.
package imm_packer_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned IMM_W    = 32;
   // imm[20] is the highest immediate bit any format places in the word
   localparam int unsigned S1_IMM_W = 21;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } immsrc_e;

   // Field bit positions inside the 32-bit instruction word
   localparam int unsigned I_IMM_MSB  = 31;
   localparam int unsigned I_IMM_LSB  = 20;
   localparam int unsigned S_HI_MSB   = 31;
   localparam int unsigned S_HI_LSB   = 25;
   localparam int unsigned S_LO_MSB   = 11;
   localparam int unsigned S_LO_LSB   = 7;
   localparam int unsigned B_SIGN_BIT = 31;
   localparam int unsigned B_HI_LSB   = 25;
   localparam int unsigned B_LO_MSB   = 11;
   localparam int unsigned B_LO_LSB   = 8;
   localparam int unsigned B_B11_BIT  = 7;
   localparam int unsigned J_SIGN_BIT = 31;
   localparam int unsigned J_HI_LSB   = 21;
   localparam int unsigned J_B11_BIT  = 20;
   localparam int unsigned J_MID_MSB  = 19;
   localparam int unsigned J_MID_LSB  = 12;

   // Template bits overwritten by each format
   localparam logic [INSTR_W-1:0] MASK_I  = 32'hFFF0_0000;
   localparam logic [INSTR_W-1:0] MASK_SB = 32'hFE00_0F80;
   localparam logic [INSTR_W-1:0] MASK_J  = 32'hFFFF_F000;

   typedef struct packed {
      logic [INSTR_W-1:0]  instr;
      immsrc_e             immsrc;
      logic [S1_IMM_W-1:0] imm;
      logic                err;
   } s1_word_t;

   function automatic logic [INSTR_W-1:0] imm_field_mask(input immsrc_e src);
      logic [INSTR_W-1:0] m;
      m = MASK_I;
      case (src)
         IMM_I:        m = MASK_I;
         IMM_S, IMM_B: m = MASK_SB;
         IMM_J:        m = MASK_J;
         default:      m = MASK_I;
      endcase
      return m;
   endfunction

   // Immediate bits placed at their format positions, zeros elsewhere
   function automatic logic [INSTR_W-1:0] imm_scatter(input immsrc_e src,
                                                      input logic [S1_IMM_W-1:0] imm);
      logic [INSTR_W-1:0] f;
      f = '0;
      case (src)
         IMM_I: f = {imm[11:0], 20'd0};
         IMM_S: f = {imm[11:5], 13'd0, imm[4:0], 7'd0};
         IMM_B: f = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
         IMM_J: f = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
         default: f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational representability check of an immediate for its format:
// sign-extension range and, for branch/jump targets, 2-byte alignment.
module imm_range_chk
   import imm_packer_pkg::*;
(
   input  logic [IMM_W-1:0] i_imm,
   input  immsrc_e          i_immsrc,
   output logic             o_err_c
);

   logic w_ok11;
   logic w_ok12;
   logic w_ok20;

   // Upper bits must all be copies of the sign bit
   assign w_ok11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
   assign w_ok12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
   assign w_ok20 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

   always_comb begin
      o_err_c = 1'b0;
      case (i_immsrc)
         IMM_I, IMM_S: o_err_c = !w_ok11;
         IMM_B:        o_err_c = !w_ok12 || i_imm[0];
         IMM_J:        o_err_c = !w_ok20 || i_imm[0];
         default:      o_err_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready immediate packer: stage 1 checks range/alignment,
// stage 2 inserts the immediate into its RISC-V fields.
// IMM_PACK_ERRCNT_EN enables the saturating errored-word counter on err_count.
module imm_packer
   import imm_packer_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter bit          ERR_ZERO = 1'b0
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [1:0]         in_immsrc,
   input  logic [IMM_W-1:0]   in_imm,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic               out_err,
   output logic [CNT_W-1:0]   err_count
);

   s1_word_t            r_s1;
   logic                r_s1_valid;
   logic                r_out_valid;
   logic [INSTR_W-1:0]  r_out_instr;
   logic                r_out_err;

   logic                w_in_err;
   logic                w_s2_free;
   logic                w_s1_adv;
   logic                w_in_fire;
   logic                w_out_fire;
   logic [S1_IMM_W-1:0] w_imm_eff;
   logic [INSTR_W-1:0]  w_packed;

   imm_range_chk u_range_chk (
      .i_imm    (in_imm),
      .i_immsrc (immsrc_e'(in_immsrc)),
      .o_err_c  (w_in_err)
   );

   // Flow control; in_ready depends on out_ready but never on in_valid
   assign w_s2_free  = !r_out_valid || out_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_free;
   assign in_ready   = !r_s1_valid || w_s2_free;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;

   // Stage 1: capture the word and its error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_in_fire) begin
         r_s1_valid <= 1'b1;
         r_s1       <= '{instr:  in_instr,
                         immsrc: immsrc_e'(in_immsrc),
                         imm:    in_imm[S1_IMM_W-1:0],
                         err:    w_in_err};
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Pack: clear the format's immediate positions, then insert the fields
   always_comb begin
      w_imm_eff = r_s1.imm;
      if (ERR_ZERO && r_s1.err) begin
         w_imm_eff = '0;
      end
      w_packed = (r_s1.instr & ~imm_field_mask(r_s1.immsrc))
               | imm_scatter(r_s1.immsrc, w_imm_eff);
   end

   // Stage 2: output register, held while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_err   <= 1'b0;
      end else if (w_s1_adv) begin
         r_out_valid <= 1'b1;
         r_out_instr <= w_packed;
         r_out_err   <= r_s1.err;
      end else if (w_out_fire) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_err   = r_out_err;

`ifdef IMM_PACK_ERRCNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_err_count;

   // Saturating count of errored words handed downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else if (w_out_fire && r_out_err && (r_err_count != CNT_MAX)) begin
         r_err_count <= r_err_count + CNT_W'(1);
      end
   end

   assign err_count = r_err_count;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Directed scoreboard bench for imm_packer: packing per format, error words,
// backpressure stability/ordering, async reset and error counter saturation.
module tb_imm_packer;

   localparam int unsigned CNT_W = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [1:0]        in_immsrc;
   logic [31:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic              out_err;
   logic [CNT_W-1:0]  err_count;

   imm_packer #(.CNT_W(CNT_W), .ERR_ZERO(1'b0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_immsrc (in_immsrc),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
      logic [1:0]  src;
      logic [31:0] imm;
   } exp_t;

   exp_t             q[$];
   int               n_cmp = 0;
   int               n_err = 0;
   logic [CNT_W-1:0] exp_cnt = '0;
   logic             prev_hold = 1'b0;
   logic [31:0]      prev_instr = '0;
   logic             prev_err = 1'b0;

`ifdef IMM_PACK_ERRCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Forward immediate extender, used to round-trip good words
   function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] s);
      case (s)
         2'b00:   return {{20{w[31]}}, w[31:20]};
         2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
         2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      endcase
   endfunction

   // Output monitor: hold stability, scoreboard pop, counter model
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_instr", out_instr, prev_instr);
            chk("hold_err", 32'(out_err), 32'(prev_err));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               e = q.pop_front();
               chk("out_instr", out_instr, e.instr);
               chk("out_err", 32'(out_err), 32'(e.err));
               if (!e.err) chk("ext_roundtrip", ext(out_instr, e.src), e.imm);
               chk("err_count", 32'(err_count), 32'(exp_cnt));
               if (CNT_ON && e.err && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
            end
         end
         prev_hold  = out_valid && !out_ready;
         prev_instr = out_instr;
         prev_err   = out_err;
      end
   end

   task automatic send(input logic [31:0] instr, input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] exp_instr, input logic exp_err);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = instr;
      in_immsrc = src;
      in_imm    = imm;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      e.instr = exp_instr;
      e.err   = exp_err;
      e.src   = src;
      e.imm   = imm;
      q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid  = 1'b0;
      in_instr  = '0;
      in_immsrc = '0;
      in_imm    = '0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // I pack and one-cycle latency
      send(32'h0000_0093, 2'b00, 32'd5, 32'h0050_0093, 1'b0);
      @(posedge clk);
      #1;
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_instr", out_instr, 32'h0050_0093);

      // Back-to-back formats and range boundaries
      send(32'h0020_A023, 2'b01, 32'd8,          32'h0020_A423, 1'b0);
      send(32'h0000_0063, 2'b10, 32'hFFFF_FFFC,  32'hFE00_0EE3, 1'b0);
      send(32'h0000_006F, 2'b11, 32'h0000_0800,  32'h0010_006F, 1'b0);
      send(32'hFFF0_0093, 2'b00, 32'd5,          32'h0050_0093, 1'b0);
      send(32'h0000_0093, 2'b00, 32'hFFFF_F800,  32'h8000_0093, 1'b0);
      send(32'h0000_0063, 2'b10, 32'h0000_0FFE,  32'h7E00_0FE3, 1'b0);
      send(32'h0000_006F, 2'b11, 32'hFFFF_FFFE,  32'hFFFF_F06F, 1'b0);
      drain();

      // Error words: truncated fields, flag set
      send(32'h0000_0093, 2'b00, 32'd2048, 32'h8000_0093, 1'b1);
      send(32'h0000_0063, 2'b10, 32'd3,    32'h0000_0163, 1'b1);
      drain();
      chk("err_count_two", 32'(err_count), CNT_ON ? 32'd2 : 32'd0);
      send(32'h0000_006F, 2'b11, 32'd1,       32'h0000_006F, 1'b1);
      send(32'h0020_A023, 2'b01, 32'h1000,    32'h0020_A023, 1'b1);
      drain();
      chk("err_count_sat", 32'(err_count), CNT_ON ? 32'd3 : 32'd0);

      // Backpressure: two words held, in_ready low while a third waits
      @(negedge clk);
      out_ready = 1'b0;
      send(32'h0000_0013, 2'b00, 32'd1, 32'h0010_0013, 1'b0);
      send(32'h0000_0013, 2'b00, 32'd2, 32'h0020_0013, 1'b0);
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = 32'h0000_0013;
      in_immsrc = 2'b00;
      in_imm    = 32'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_instr", out_instr, 32'h0010_0013);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send(32'h0000_0013, 2'b00, 32'd3, 32'h0030_0013, 1'b0);
      send(32'h0000_0013, 2'b00, 32'd4, 32'h0040_0013, 1'b0);
      drain();

      // Asynchronous reset mid-stream drops in-flight words
      send(32'h0000_0093, 2'b00, 32'd2048, 32'h8000_0093, 1'b1);
      send(32'h0000_0013, 2'b00, 32'd7,    32'h0070_0013, 1'b0);
      send(32'h0000_0013, 2'b00, 32'd8,    32'h0080_0013, 1'b0);
      #2;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_count", 32'(err_count), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      exp_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      send(32'h0000_0013, 2'b00, 32'd9, 32'h0090_0013, 1'b0);
      drain();
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
